osd_mam_if_arb: RTL
===================

# osd_mam_if_arb

Transaction-level arbiter that shares one MAM memory-access port (request, write-data and read-data streams feeding the Wishbone MAM interface) between N_PORTS requesters. It grants one requester at a time for a complete transaction and forwards its request and data beats to the single downstream port. It releases the grant only after the final data beat has been handshaked. It sits between the MAM debug module(s) or other memory clients and `osd_mam_wb_if`.

## Interface
- N_PORTS, 2: number of upstream requesters (2..8).
- DATA_WIDTH, 16: data width in bits (multiple of 16).
- ADDR_WIDTH, 32: address width in bits.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_req_valid / s_req_ready  in / out  N_PORTS  per-port request handshake.
- s_req_rw, s_req_burst  in  N_PORTS  per-port 0 read / 1 write; 0 single / 1 incremental burst.
- s_req_addr  in  N_PORTS*ADDR_WIDTH  per-port base address; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_req_beats  in  N_PORTS*14  per-port burst length.
- s_write_valid / s_write_ready  in / out  N_PORTS  per-port write-data handshake.
- s_write_data, s_write_strb  in  N_PORTS*DATA_WIDTH, N_PORTS*DATA_WIDTH/8  per-port write data and byte strobes.
- s_read_valid / s_read_ready  out / in  N_PORTS  per-port read-data handshake.
- s_read_data  out  N_PORTS*DATA_WIDTH  read data, broadcast to all slices.
- m_req_valid, m_req_ready, m_req_rw, m_req_addr, m_req_burst, m_req_beats  out, in, out, out, out, out  1, 1, 1, ADDR_WIDTH, 1, 14  downstream request.
- m_write_valid, m_write_ready, m_write_data, m_write_strb  out, in, out, out  1, 1, DATA_WIDTH, DATA_WIDTH/8  downstream write data.
- m_read_valid, m_read_ready, m_read_data  in, out, in  1, 1, DATA_WIDTH  downstream read data.
- grant  out  N_PORTS  one-hot current owner; all-zero in IDLE.

## Operation
- States: IDLE, REQ, DATA.
- IDLE
  - All valid/ready outputs are 0.
  - If any s_req_valid is set, select a winner, register grant/owner and go to REQ.
  - The request is not forwarded in the IDLE cycle.
- REQ
  - m_req_valid = s_req_valid[owner].
  - m_req_* fields come from the owner; s_req_ready[owner] = m_req_ready.
  - Data channels are gated: m_write_valid=0, m_read_ready=0, all s_write_ready/s_read_valid=0.
  - On the handshake (valid & ready):
    - latch rw;
    - load beat counter = (burst ? beats : 1), with beats==0 treated as 1;
    - go to DATA.
- DATA, write (rw=1)
  - m_write_valid/data/strb come from the owner; s_write_ready[owner] = m_write_ready.
  - The read channel is gated.
- DATA, read (rw=0)
  - s_read_valid[owner] = m_read_valid; m_read_ready = s_read_ready[owner].
  - The write channel is gated.
- Beat counting: each handshake on the active data channel decrements the counter. The handshake with counter==1 returns to IDLE and updates the priority pointer to the owner.
- Non-owner ports: ready/valid outputs are always 0.
- Round-robin: search starts at (pointer+1) mod N_PORTS. Reset pointer = N_PORTS-1, so port 0 wins first.
- Requests that arrive or drop while another port owns the bus are ignored until the next IDLE arbitration.
- Owner dropping s_req_valid while in REQ: stay in REQ. Requesters must not retract.

## Timing
- Reset values: state IDLE, grant 0, owner 0, pointer N_PORTS-1, counter 0. All m_*_valid, m_read_ready, s_*_ready and s_read_valid are 0.
- Reset mid-transaction: return to IDLE the next cycle with the in-flight transaction abandoned. The downstream port shares rst_i.
- Latency: s_req_valid rising in IDLE gives m_req_valid=1 in the following cycle.
- Data paths: combinational pass-through, zero added cycles per beat.
- Gap between transactions: at least one IDLE cycle after the last beat.
- Simultaneous requests in IDLE: exactly one grant per arbitration.
- Counter width: 14 bits; beats up to 16383.

## Configuration
- OSD_MAM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. The pointer is not used or updated.
  - Undefined (default): round-robin as above.

## Test plan
- Single port 0 write, burst=0, data 0xA5A5, strb 2'b11 -> one downstream request with addr passed unchanged, one write beat 0xA5A5, grant returns to 0 after the beat.
- Port 1 read burst, beats=4, downstream returns 0x0001..0x0004 -> s_read_data sequence on port 1 only, s_read_valid[0] stays 0, IDLE after the 4th handshake.
- Both ports request in the same cycle, continuously, for 4 transactions -> grant order 0,1,0,1 (round-robin). With OSD_MAM_ARB_FIXED_PRIO_EN, grant order is 0,0,0,0.
- Port 0 burst write beats=3 with write_valid stalled 5 cycles before beat 2 -> no grant change, exactly 3 write handshakes, port 1 request waits until after beat 3.
- burst=1, beats=0 -> treated as a single beat; IDLE after one handshake.
- rst_i asserted mid-DATA (beat 2 of 8) -> next cycle all valids/readys 0, grant 0. A new request after reset is granted to port 0.

Source files
------------

// File: rtl/osd_mam_if_arb.sv
// Transaction-level arbiter sharing one MAM memory-access port among N_PORTS requesters.
// Define OSD_MAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module osd_mam_if_arb #(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_PORTS-1:0]              s_req_valid,
    output logic [N_PORTS-1:0]              s_req_ready,
    input  logic [N_PORTS-1:0]              s_req_rw,
    input  logic [N_PORTS-1:0]              s_req_burst,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [N_PORTS*14-1:0]           s_req_beats,
    input  logic [N_PORTS-1:0]              s_write_valid,
    output logic [N_PORTS-1:0]              s_write_ready,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   s_write_data,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0] s_write_strb,
    output logic [N_PORTS-1:0]              s_read_valid,
    input  logic [N_PORTS-1:0]              s_read_ready,
    output logic [N_PORTS*DATA_WIDTH-1:0]   s_read_data,
    output logic                            m_req_valid,
    input  logic                            m_req_ready,
    output logic                            m_req_rw,
    output logic [ADDR_WIDTH-1:0]           m_req_addr,
    output logic                            m_req_burst,
    output logic [13:0]                     m_req_beats,
    output logic                            m_write_valid,
    input  logic                            m_write_ready,
    output logic [DATA_WIDTH-1:0]           m_write_data,
    output logic [DATA_WIDTH/8-1:0]         m_write_strb,
    input  logic                            m_read_valid,
    output logic                            m_read_ready,
    input  logic [DATA_WIDTH-1:0]           m_read_data,
    output logic [N_PORTS-1:0]              grant
);

    localparam int unsigned IdxW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StReq, StData} state_e;

    state_e              state_q, state_d;
    logic [N_PORTS-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [13:0]         cnt_q, cnt_d;
    logic                rw_q, rw_d;
`ifndef OSD_MAM_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]     ptr_q, ptr_d;
`endif

    logic                win_found;
    logic [IdxW-1:0]     win_idx;
    logic [IdxW-1:0]     cand_idx;
    int unsigned         cand;
    logic                data_hs;

    // Request fields and write data always follow the current owner; valids are gated below.
    assign m_req_rw     = s_req_rw[owner_q];
    assign m_req_burst  = s_req_burst[owner_q];
    assign m_req_addr   = s_req_addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_req_beats  = s_req_beats[owner_q*14 +: 14];
    assign m_write_data = s_write_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign m_write_strb = s_write_strb[owner_q*StrbW +: StrbW];
    assign s_read_data  = {N_PORTS{m_read_data}};
    assign grant        = grant_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
`ifdef OSD_MAM_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (32'(ptr_q) + k + 1) % N_PORTS;
`endif
            cand_idx = cand[IdxW-1:0];
            if (!win_found && s_req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        rw_d          = rw_q;
`ifndef OSD_MAM_ARB_FIXED_PRIO_EN
        ptr_d         = ptr_q;
`endif
        m_req_valid   = 1'b0;
        s_req_ready   = '0;
        m_write_valid = 1'b0;
        s_write_ready = '0;
        m_read_ready  = 1'b0;
        s_read_valid  = '0;
        data_hs       = 1'b0;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    state_d          = StReq;
                end
            end
            StReq: begin
                m_req_valid          = s_req_valid[owner_q];
                s_req_ready[owner_q] = m_req_ready;
                if (s_req_valid[owner_q] && m_req_ready) begin
                    rw_d    = s_req_rw[owner_q];
                    // A zero-length burst still moves one beat.
                    cnt_d   = (s_req_burst[owner_q] && (m_req_beats != 14'd0)) ? m_req_beats
                                                                                : 14'd1;
                    state_d = StData;
                end
            end
            StData: begin
                if (rw_q) begin
                    m_write_valid          = s_write_valid[owner_q];
                    s_write_ready[owner_q] = m_write_ready;
                    data_hs                = s_write_valid[owner_q] && m_write_ready;
                end else begin
                    s_read_valid[owner_q] = m_read_valid;
                    m_read_ready          = s_read_ready[owner_q];
                    data_hs               = m_read_valid && s_read_ready[owner_q];
                end
                if (data_hs) begin
                    cnt_d = cnt_q - 14'd1;
                    if (cnt_q == 14'd1) begin
                        state_d = StIdle;
                        grant_d = '0;
`ifndef OSD_MAM_ARB_FIXED_PRIO_EN
                        ptr_d   = owner_q;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
`ifndef OSD_MAM_ARB_FIXED_PRIO_EN
            ptr_q   <= IdxW'(N_PORTS - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
`ifndef OSD_MAM_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
